// File: rtl/pixel_streamer.sv
// pixel_streamer
// Frame-memory source for the convolution window path. Holds one
// ROW_SIZE x COLUMN_SIZE image loaded through a simple write port and, on
// start, replays it in raster order, optionally wrapped in a PAD-pixel ring
// of zeros. The downstream window generator must be built for the padded
// width W = ROW_SIZE + 2*PAD when PAD > 0.
//
// Ports:
//   clock          single clock, all logic on posedge
//   resetn         asynchronous active-low reset (memory is not cleared)
//   wr_en          frame-memory write strobe (ignored while busy)
//   wr_addr        raster write address row*ROW_SIZE+col
//   wr_data        pixel to store
//   start          begin one frame replay (only honoured in IDLE)
//   stall          back-pressure: blocks pixel issue in the current cycle
//   data_out       streamed pixel, 0 when data_out_valid is low
//   data_out_valid data_out carries a pixel this cycle
//   busy           replay in progress
//   done           one-cycle pulse alongside the last pixel
module pixel_streamer #(
    parameter int DATA_SIZE   = 16,
    parameter int ROW_SIZE    = 5,
    parameter int COLUMN_SIZE = 5,
    parameter int PAD         = 0,
    localparam int W          = ROW_SIZE + 2 * PAD,
    localparam int H          = COLUMN_SIZE + 2 * PAD,
    localparam int AW         = $clog2(ROW_SIZE * COLUMN_SIZE)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 start,
    input  logic                 stall,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int DEPTH = ROW_SIZE * COLUMN_SIZE;
    localparam int CW    = $clog2(W + 1);
    localparam int RW    = $clog2(H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic                   busy_q, done_q, valid_q;
    logic [DATA_SIZE-1:0]   data_q;
    logic                   issue_s;
    logic                   pad_s;

    logic [DATA_SIZE-1:0]   frame_mem [DEPTH];

    // Pad ring test on the padded-frame position; int casts keep PAD=0 legal
    always_comb begin
        pad_s = (int'(row_q) < PAD) || (int'(row_q) >= PAD + COLUMN_SIZE) ||
                (int'(col_q) < PAD) || (int'(col_q) >= PAD + ROW_SIZE);
    end

    // Next-state, counter and read-address logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        issue_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
                if (start) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (!stall) begin
                    issue_s = 1'b1;
                    // Non-pad positions are visited in memory order, so the
                    // read address is a plain counter advanced on each of them.
                    if (!pad_s) begin
                        addr_d = addr_q + AW'(1);
                    end else begin
                        addr_d = addr_q;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and status flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            valid_q <= issue_s;
        end
    end

    // Frame memory write port; locked out during a replay
    always_ff @(posedge clock) begin
        if (wr_en && !busy_q && (int'(wr_addr) < DEPTH)) begin
            frame_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; pad positions and idle cycles present zero
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_q <= '0;
        end else if (issue_s && !pad_s) begin
            data_q <= frame_mem[addr_q];
        end else begin
            data_q <= '0;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: one unpadded and one PAD=1 instance
// share a clock and reset; each replay is captured cycle by cycle and
// compared against hand-derived raster expectations.
module tb_pixel_streamer;

    logic        clock;
    logic        resetn;
    logic        wr_en0, wr_en1;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start0, start1;
    logic        stall;
    logic [15:0] dout0, dout1;
    logic        dv0, dv1, busy0, busy1, done0, done1;

    int total;
    int bad;

    int vals[$];
    int cycs[$];
    int done_cnt, done_cyc, busy_cnt, busy_first, busy_last, busy_pre, zero_bad;

    pixel_streamer #(.DATA_SIZE(16), .ROW_SIZE(5), .COLUMN_SIZE(5), .PAD(0)) u_dut0 (
        .clock(clock), .resetn(resetn), .wr_en(wr_en0), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start0), .stall(stall), .data_out(dout0),
        .data_out_valid(dv0), .busy(busy0), .done(done0)
    );

    pixel_streamer #(.DATA_SIZE(16), .ROW_SIZE(5), .COLUMN_SIZE(5), .PAD(1)) u_dut1 (
        .clock(clock), .resetn(resetn), .wr_en(wr_en1), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start1), .stall(stall), .data_out(dout1),
        .data_out_valid(dv1), .busy(busy1), .done(done1)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pix(input int pad, input int i);
        int w, r, c;
        w = 5 + 2 * pad;
        r = i / w;
        c = i % w;
        if (r < pad || r >= pad + 5 || c < pad || c >= pad + 5) return 0;
        return (r - pad) * 5 + (c - pad) + 1;
    endfunction

    function automatic int val_at(input int i);
        if (i < vals.size()) return vals[i];
        return -1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i >= 0 && i < cycs.size()) return cycs[i];
        return -1;
    endfunction

    // Start a replay on one instance and capture budget cycles of output.
    // ex_cyc: cycle in which an extra start pulse (and optional write of
    // 0xFFFF to address 0 when ex_wr) is presented.
    task automatic replay(input int inst, input int st_lo, input int st_hi,
                          input int budget, input int ex_cyc, input int ex_wr);
        logic v, b, dn;
        logic [15:0] d;
        vals.delete();
        cycs.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        busy_first = -1; busy_last = -1; zero_bad = 0;
        @(negedge clock);
        busy_pre = (inst == 0) ? int'(busy0) : int'(busy1);
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            start0 = 1'b0; start1 = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0;
            stall = (c >= st_lo && c <= st_hi);
            if (c == ex_cyc) begin
                if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
                if (ex_wr != 0) begin
                    if (inst == 0) wr_en0 = 1'b1; else wr_en1 = 1'b1;
                    wr_addr = 5'd0;
                    wr_data = 16'hFFFF;
                end
            end
            v  = (inst == 0) ? dv0 : dv1;
            d  = (inst == 0) ? dout0 : dout1;
            b  = (inst == 0) ? busy0 : busy1;
            dn = (inst == 0) ? done0 : done1;
            if (v) begin
                vals.push_back(int'(d));
                cycs.push_back(c);
            end else if (d != 16'd0) begin
                zero_bad++;
            end
            if (b) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (dn) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        stall = 1'b0;
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
    endtask

    task automatic check_values(input string tag, input int pad);
        int n;
        n = (5 + 2 * pad) * (5 + 2 * pad);
        check({tag, "_count"}, vals.size(), n);
        check({tag, "_zero_when_invalid"}, zero_bad, 0);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_pix%0d", tag, i), val_at(i), exp_pix(pad, i));
        end
    endtask

    // Main directed sequence
    initial begin
        int hits;
        total = 0; bad = 0;
        resetn = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; wr_addr = 5'd0;
        wr_data = 16'd0; start0 = 1'b0; start1 = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_valid", int'(dv0), 0);
        check("rst_data", int'(dout0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_valid_pad", int'(dv1), 0);
        resetn = 1'b1;

        // Load pixel = address + 1 into both frames
        for (int a = 0; a < 25; a++) begin
            @(negedge clock);
            wr_en0 = 1'b1; wr_en1 = 1'b1;
            wr_addr = 5'(a);
            wr_data = 16'(a + 1);
        end
        @(negedge clock);
        wr_en0 = 1'b0; wr_en1 = 1'b0;

        // Plain unpadded replay
        replay(0, 0, -1, 30, -1, 0);
        check_values("p0", 0);
        check("p0_first_cyc", cyc_at(0), 2);
        check("p0_last_cyc", cyc_at(24), 26);
        check("p0_done_cnt", done_cnt, 1);
        check("p0_done_cyc", done_cyc, 26);
        check("p0_busy_first", busy_first, 1);
        check("p0_busy_last", busy_last, 26);
        check("p0_busy_cnt", busy_cnt, 26);

        // Padded replay
        replay(1, 0, -1, 55, -1, 0);
        check_values("p1", 1);
        check("p1_last_cyc", cyc_at(48), 50);
        check("p1_done_cyc", done_cyc, cyc_at(48));
        check("p1_done_cnt", done_cnt, 1);
        check("p1_busy_last", busy_last, 50);

        // Stall held in cycles 5..7
        replay(0, 5, 7, 33, -1, 0);
        check_values("st", 0);
        hits = 0;
        foreach (cycs[i]) if (cycs[i] >= 6 && cycs[i] <= 8) hits++;
        check("st_no_valid_6_8", hits, 0);
        check("st_valid_cyc5", cyc_at(3), 5);
        check("st_valid_cyc9", cyc_at(4), 9);
        check("st_last_cyc", cyc_at(24), 29);
        check("st_done_cyc", done_cyc, 29);
        check("st_busy_last", busy_last, 29);

        // Asynchronous reset in cycle 10 of a replay
        @(negedge clock);
        start0 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            start0 = 1'b0;
        end
        check("mid_valid_before", int'(dv0), 1);
        check("mid_data_before", int'(dout0), 9);
        resetn = 1'b0;
        #1;
        check("mid_valid_rst", int'(dv0), 0);
        check("mid_busy_rst", int'(busy0), 0);
        check("mid_done_rst", int'(done0), 0);
        check("mid_data_rst", int'(dout0), 0);
        @(negedge clock);
        resetn = 1'b1;
        replay(0, 0, -1, 30, -1, 0);
        check_values("after_rst", 0);
        check("after_rst_done_cyc", done_cyc, 26);

        // Start pulse and write attempt during a replay
        replay(0, 0, -1, 30, 5, 1);
        check_values("busy_wr", 0);
        check("busy_wr_busy_last", busy_last, 26);
        check("busy_wr_busy_cnt", busy_cnt, 26);
        check("busy_wr_done_cnt", done_cnt, 1);
        replay(0, 0, -1, 30, -1, 0);
        check("busy_wr_next_first", val_at(0), 1);
        check("busy_wr_next_count", vals.size(), 25);

        // Start in the DONE cycle is ignored; one cycle later it launches
        replay(0, 0, -1, 26, 26, 0);
        check("dstart_done_cyc", done_cyc, 26);
        replay(0, 0, -1, 30, -1, 0);
        check("dstart_idle_busy", busy_pre, 0);
        check_values("dstart_next", 0);
        check("dstart_next_done", done_cyc, 26);
        check("dstart_next_busy_first", busy_first, 1);

        // A write in IDLE is seen by a replay started the next cycle
        @(negedge clock);
        wr_en0 = 1'b1; wr_addr = 5'd0; wr_data = 16'd77;
        replay(0, 0, -1, 30, -1, 0);
        check("idle_wr_first", val_at(0), 77);
        check("idle_wr_second", val_at(1), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
